// File: rtl/urv_ahb_defs.sv
// Shared AHB-Lite encodings and data-bus master identifiers for the uRV core.
package urv_ahb_defs;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_B = 3'b000;
   localparam logic [2:0] HSIZE_H = 3'b001;
   localparam logic [2:0] HSIZE_W = 3'b010;

   localparam logic M_CORE = 1'b0;
   localparam logic M_DBG  = 1'b1;

endpackage

// File: rtl/urv_dbus_grant.sv
// Data-bus grant decision with a streak limiter so neither master can starve the other.
module urv_dbus_grant
   import urv_ahb_defs::*;
#(
   parameter int unsigned LOCK_MAX    = 4,
   parameter bit          M0_PRIORITY = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req,
   input  logic       hready,
   output logic       g,
   output logic       accept
);

   localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

   logic       last_grant_reg;
   logic [3:0] streak_reg;

   always_comb begin
      g = last_grant_reg;
      if (hready) begin
         if (&req) begin
            if (streak_reg == 4'd0)
               g = M0_PRIORITY ? M_CORE : ~last_grant_reg;
            else if (streak_reg >= LOCK_LIM)
               g = ~last_grant_reg;
         end else if (req[0]) begin
            g = M_CORE;
         end else if (req[1]) begin
            g = M_DBG;
         end
      end
   end

   assign accept = hready && req[g];

   // Streak counts consecutive accepts for the same master and restarts on any idle bus cycle.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         last_grant_reg <= M_CORE;
         streak_reg     <= 4'd0;
      end else if (accept) begin
         last_grant_reg <= g;
         if (g != last_grant_reg)
            streak_reg <= 4'd1;
         else if (streak_reg < LOCK_LIM)
            streak_reg <= streak_reg + 4'd1;
      end else if (hready) begin
         streak_reg <= 4'd0;
      end
   end

endmodule

// File: rtl/urv_dbus_arbiter.sv
// Two-master AHB-Lite data-bus arbiter: address/data muxing plus a one-entry
// read-data hold for a data owner whose next address lost arbitration.
module urv_dbus_arbiter
   import urv_ahb_defs::*;
#(
   parameter int unsigned LOCK_MAX    = 4,
   parameter bit          M0_PRIORITY = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] m0_haddr_i,
   input  logic [1:0]  m0_htrans_i,
   input  logic        m0_hwrite_i,
   input  logic [2:0]  m0_hsize_i,
   input  logic [31:0] m0_hwdata_i,
   output logic        m0_hready_o,
   output logic [31:0] m0_hrdata_o,
   input  logic [31:0] m1_haddr_i,
   input  logic [1:0]  m1_htrans_i,
   input  logic        m1_hwrite_i,
   input  logic [2:0]  m1_hsize_i,
   input  logic [31:0] m1_hwdata_i,
   output logic        m1_hready_o,
   output logic [31:0] m1_hrdata_o,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [31:0] HRDATA
);

   logic [1:0]        req;
   logic              g;
   logic              accept;
   logic              capture;
   logic [1:0]        hready_vec;
   logic [1:0][31:0]  rdata_vec;

   logic              data_valid_reg;
   logic              data_owner_reg;
   logic              hold_valid_reg;
   logic              hold_owner_reg;
   logic [31:0]       hold_data_reg;

   assign req = {m1_htrans_i[1], m0_htrans_i[1]};

   urv_dbus_grant #(
      .LOCK_MAX    (LOCK_MAX),
      .M0_PRIORITY (M0_PRIORITY)
   ) u_grant (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req    (req),
      .hready (HREADY),
      .g      (g),
      .accept (accept)
   );

   assign HADDR  = g ? m1_haddr_i  : m0_haddr_i;
   assign HWRITE = g ? m1_hwrite_i : m0_hwrite_i;
   assign HSIZE  = g ? m1_hsize_i  : m0_hsize_i;
   assign HTRANS = req[g] ? (g ? m1_htrans_i : m0_htrans_i) : HTRANS_IDLE;
   assign HWDATA = data_owner_reg ? m1_hwdata_i : m0_hwdata_i;

   // The finishing data owner lost its next address phase: park its read data.
   assign capture = HREADY && data_valid_reg && req[data_owner_reg] && (g != data_owner_reg);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_master
         localparam logic ID = 1'(gi);
         assign hready_vec[gi] = req[gi] ? (HREADY && (g == ID)) :
                                 (hold_valid_reg && hold_owner_reg == ID) ? 1'b1 :
                                 (data_valid_reg && data_owner_reg == ID) ? HREADY : 1'b1;
         assign rdata_vec[gi]  = (hold_valid_reg && hold_owner_reg == ID) ? hold_data_reg : HRDATA;
      end
   endgenerate

   assign m0_hready_o = hready_vec[0];
   assign m1_hready_o = hready_vec[1];
   assign m0_hrdata_o = rdata_vec[0];
   assign m1_hrdata_o = rdata_vec[1];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         data_valid_reg <= 1'b0;
         data_owner_reg <= M_CORE;
         hold_valid_reg <= 1'b0;
         hold_owner_reg <= M_CORE;
         hold_data_reg  <= 32'd0;
      end else begin
         if (accept) begin
            data_valid_reg <= 1'b1;
            data_owner_reg <= g;
         end else if (HREADY) begin
            data_valid_reg <= 1'b0;
         end
         // A fresh capture overrides release of an older hold in the same cycle.
         if (capture) begin
            hold_data_reg  <= HRDATA;
            hold_owner_reg <= data_owner_reg;
            hold_valid_reg <= 1'b1;
         end else if (hold_valid_reg && hready_vec[hold_owner_reg]) begin
            hold_valid_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_urv_dbus_arbiter.sv
// Self-checking bench for urv_dbus_arbiter: address-phase scoreboard plus directed data checks.
module tb_urv_dbus_arbiter;
   import urv_ahb_defs::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
   logic [1:0]  m0_htrans, m1_htrans;
   logic        m0_hwrite, m1_hwrite;
   logic [2:0]  m0_hsize, m1_hsize;
   logic        m0_hready, m1_hready;
   logic [31:0] m0_hrdata, m1_hrdata;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic        HWRITE, HREADY;
   logic [2:0]  HSIZE;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];
   int n0, n1, e0, e1;

   always #5 clk = ~clk;

   urv_dbus_arbiter #(.LOCK_MAX(4), .M0_PRIORITY(1'b1)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .m0_haddr_i(m0_haddr), .m0_htrans_i(m0_htrans), .m0_hwrite_i(m0_hwrite),
      .m0_hsize_i(m0_hsize), .m0_hwdata_i(m0_hwdata), .m0_hready_o(m0_hready), .m0_hrdata_o(m0_hrdata),
      .m1_haddr_i(m1_haddr), .m1_htrans_i(m1_htrans), .m1_hwrite_i(m1_hwrite),
      .m1_hsize_i(m1_hsize), .m1_hwdata_i(m1_hwdata), .m1_hready_o(m1_hready), .m1_hrdata_o(m1_hrdata),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRDATA(HRDATA)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   // Every accepted address phase is compared against the next expected address.
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst_n && HREADY && HTRANS[1]) begin
         e = 32'hDEAD_0000;
         if (exp_q.size() != 0) e = exp_q.pop_front();
         check_val("sb_haddr", HADDR, e);
         $display("txn haddr=%08h hwrite=%0b hsize=%0d", HADDR, HWRITE, HSIZE);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      rst_n = 1'b0;
      m0_haddr = 32'd0; m1_haddr = 32'd0; m0_hwdata = 32'd0; m1_hwdata = 32'd0;
      m0_htrans = HTRANS_IDLE; m1_htrans = HTRANS_IDLE;
      m0_hwrite = 1'b0; m1_hwrite = 1'b0; m0_hsize = HSIZE_W; m1_hsize = HSIZE_W;
      HREADY = 1'b1; HRDATA = 32'h1111_1111;

      // Reset state
      #3;
      check_val("rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
      check_val("rst_m0_rdy", 32'(m0_hready), 32'd1);
      check_val("rst_m1_rdy", 32'(m1_hready), 32'd1);
      check_val("rst_m0_rdata", m0_hrdata, 32'h1111_1111);
      check_val("rst_haddr", HADDR, m0_haddr);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();

      // Single m0 read
      m0_htrans = HTRANS_NONSEQ; m0_haddr = 32'h100;
      exp_q.push_back(32'h100);
      settle();
      check_val("t1_haddr", HADDR, 32'h100);
      check_val("t1_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
      cyc();
      m0_htrans = HTRANS_IDLE; HRDATA = 32'hDEAD_BEEF;
      settle();
      check_val("t1_m0_rdata", m0_hrdata, 32'hDEAD_BEEF);
      check_val("t1_m0_rdy", 32'(m0_hready), 32'd1);
      cyc();

      // Simultaneous requests: m0 wins by priority, m1 follows
      m0_htrans = HTRANS_NONSEQ; m0_haddr = 32'h200;
      m1_htrans = HTRANS_NONSEQ; m1_haddr = 32'h1000_0200;
      exp_q.push_back(32'h200);
      settle();
      check_val("t2_m0_rdy", 32'(m0_hready), 32'd1);
      check_val("t2_m1_rdy", 32'(m1_hready), 32'd0);
      cyc();
      m0_htrans = HTRANS_IDLE; HRDATA = 32'h2222_2222;
      exp_q.push_back(32'h1000_0200);
      settle();
      check_val("t2_m1_rdy2", 32'(m1_hready), 32'd1);
      check_val("t2_m0_rdata", m0_hrdata, 32'h2222_2222);
      cyc();
      m1_htrans = HTRANS_IDLE; HRDATA = 32'h3333_3333;
      settle();
      check_val("t2_m1_rdata", m1_hrdata, 32'h3333_3333);
      cyc();

      // Continuous contention: 4 x m0, 4 x m1, 4 x m0, then a final m1
      e0 = 0; e1 = 0;
      for (int k = 0; k < 13; k++) begin
         if (k < 4 || (k >= 8 && k < 12)) begin
            exp_q.push_back(32'h300 + 32'(4 * e0)); e0++;
         end else begin
            exp_q.push_back(32'h1000_0300 + 32'(4 * e1)); e1++;
         end
      end
      n0 = 0; n1 = 0;
      for (int c = 1; c <= 13; c++) begin
         m0_htrans = (n0 < 8) ? HTRANS_NONSEQ : HTRANS_IDLE;
         m0_haddr  = 32'h300 + 32'(4 * n0);
         m1_htrans = (n1 < 5) ? HTRANS_NONSEQ : HTRANS_IDLE;
         m1_haddr  = 32'h1000_0300 + 32'(4 * n1);
         HRDATA    = (c == 5) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(c));
         settle();
         if (c >= 5 && c <= 8) begin
            check_val("t4_m0_rdy_held", 32'(m0_hready), 32'd0);
            check_val("t4_m0_hold", m0_hrdata, 32'h1234_5678);
         end
         if (c == 9) begin
            check_val("t4_m0_rdy_regrant", 32'(m0_hready), 32'd1);
            check_val("t4_m0_hold_release", m0_hrdata, 32'h1234_5678);
         end
         if (c == 13) check_val("t3_m1_hold", m1_hrdata, 32'hC0DE_0009);
         if (m0_hready && m0_htrans[1]) n0++;
         if (m1_hready && m1_htrans[1]) n1++;
         cyc();
      end
      m0_htrans = HTRANS_IDLE; m1_htrans = HTRANS_IDLE; HRDATA = 32'h4444_4444;
      settle();
      check_val("t3_n0", 32'(n0), 32'd8);
      check_val("t3_n1", 32'(n1), 32'd5);
      check_val("t3_m1_rdata", m1_hrdata, 32'h4444_4444);
      cyc();

      // m1 write with three slave wait states in its data phase
      m1_htrans = HTRANS_NONSEQ; m1_haddr = 32'h1000_0500; m1_hwrite = 1'b1;
      exp_q.push_back(32'h1000_0500);
      settle();
      check_val("t5_hwrite", 32'(HWRITE), 32'd1);
      cyc();
      m1_htrans = HTRANS_IDLE; m1_hwrite = 1'b0; m1_hwdata = 32'hA5A5_A5A5;
      m0_hwdata = 32'h0F0F_0F0F; m0_htrans = HTRANS_NONSEQ; m0_haddr = 32'h500;
      HREADY = 1'b0;
      for (int w = 0; w < 3; w++) begin
         settle();
         check_val("t5_hwdata", HWDATA, 32'hA5A5_A5A5);
         check_val("t5_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
         check_val("t5_haddr", HADDR, 32'h1000_0500);
         check_val("t5_m0_rdy", 32'(m0_hready), 32'd0);
         check_val("t5_m1_rdy", 32'(m1_hready), 32'd0);
         cyc();
      end
      HREADY = 1'b1;
      exp_q.push_back(32'h500);
      settle();
      check_val("t5_hwdata_last", HWDATA, 32'hA5A5_A5A5);
      check_val("t5_m1_done", 32'(m1_hready), 32'd1);
      check_val("t5_m0_acc", 32'(m0_hready), 32'd1);
      cyc();
      m0_htrans = HTRANS_IDLE; HRDATA = 32'h55AA_55AA;
      settle();
      check_val("t5_m0_rdata", m0_hrdata, 32'h55AA_55AA);
      check_val("t5_hwdata_m0", HWDATA, 32'h0F0F_0F0F);
      cyc();

      // Reset while m1 is in its data phase and m0 has a held read
      for (int k = 0; k < 4; k++) exp_q.push_back(32'h600 + 32'(4 * k));
      exp_q.push_back(32'h1000_0600);
      n0 = 0; n1 = 0;
      for (int c = 1; c <= 6; c++) begin
         m0_htrans = HTRANS_NONSEQ; m0_haddr = 32'h600 + 32'(4 * n0);
         m1_htrans = HTRANS_NONSEQ; m1_haddr = 32'h1000_0600 + 32'(4 * n1);
         HRDATA    = (c == 5) ? 32'h1234_5678 : (32'h6666_0000 | 32'(c));
         settle();
         if (c < 6) begin
            if (m0_hready) n0++;
            if (m1_hready) n1++;
            cyc();
         end
      end
      check_val("t6_m0_hold", m0_hrdata, 32'h1234_5678);
      check_val("t6_m0_rdy", 32'(m0_hready), 32'd0);
      rst_n = 1'b0;
      #1;
      check_val("t6_rst_rdata", m0_hrdata, 32'h6666_0006);
      check_val("t6_rst_m0_rdy", 32'(m0_hready), 32'd1);
      check_val("t6_rst_m1_rdy", 32'(m1_hready), 32'd0);
      check_val("t6_rst_haddr", HADDR, 32'h610);
      cyc();
      rst_n = 1'b1;
      exp_q.push_back(32'h610);
      settle();
      check_val("t6_m1_denied", 32'(m1_hready), 32'd0);
      cyc();
      m0_htrans = HTRANS_IDLE;
      exp_q.push_back(32'h1000_0604);
      settle();
      check_val("t6_m1_acc", 32'(m1_hready), 32'd1);
      cyc();
      m1_htrans = HTRANS_IDLE;
      cyc();
      cyc();

      check_val("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
